// File: rtl/div_subshift.sv
// ============================================================================
// Module      : div_subshift
// Description : Sequential restoring divider, one quotient bit per cycle,
//               signed or unsigned, with divide-by-zero and overflow results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_subshift #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state_q, w_state_d;
  logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
  logic [DATA_W:0]   r_rem_q,   w_rem_d;
  logic [DATA_W-1:0] r_dvd_q,   w_dvd_d;
  logic [DATA_W-1:0] r_dvs_q,   w_dvs_d;
  logic              r_qneg_q,  w_qneg_d;
  logic              r_rneg_q,  w_rneg_d;
  logic              r_dz_q,    w_dz_d;
  logic [DATA_W-1:0] w_quotient_d;
  logic [DATA_W-1:0] w_remainder_d;
  logic              w_done_d;

  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W:0]   w_diff;
  logic              w_keep;
  logic [DATA_W:0]   w_rem_step;
  logic [DATA_W-1:0] w_quo_step;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;

  // The partial remainder is always below the divisor, so its top bit is
  // zero before the shift and can be dropped without loss.
  always_comb begin
    w_rem_sh   = {r_rem_q[DATA_W-1:0], r_dvd_q[DATA_W-1]};
    w_diff     = w_rem_sh - {1'b0, r_dvs_q};
    w_keep     = ~w_diff[DATA_W];
    w_rem_step = w_keep ? w_diff : w_rem_sh;
    w_quo_step = {r_dvd_q[DATA_W-2:0], w_keep};
    w_quo_fix  = r_dz_q ? '1 : (r_qneg_q ? (~w_quo_step + 1'b1) : w_quo_step);
    w_rem_fix  = r_rneg_q ? (~w_rem_step[DATA_W-1:0] + 1'b1) : w_rem_step[DATA_W-1:0];
    w_a_mag    = (sign & dividend[DATA_W-1]) ? (~dividend + 1'b1) : dividend;
    w_b_mag    = (sign & divisor[DATA_W-1])  ? (~divisor + 1'b1)  : divisor;
  end

  always_comb begin
    w_state_d     = r_state_q;
    w_cnt_d       = r_cnt_q;
    w_rem_d       = r_rem_q;
    w_dvd_d       = r_dvd_q;
    w_dvs_d       = r_dvs_q;
    w_qneg_d      = r_qneg_q;
    w_rneg_d      = r_rneg_q;
    w_dz_d        = r_dz_q;
    w_quotient_d  = quotient;
    w_remainder_d = remainder;
    w_done_d      = 1'b0;
    case (r_state_q)
      S_IDLE: begin
        if (en) begin
          w_rem_d   = '0;
          w_dvd_d   = w_a_mag;
          w_dvs_d   = w_b_mag;
          w_qneg_d  = sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          w_rneg_d  = sign & dividend[DATA_W-1];
          w_dz_d    = (divisor == '0);
          w_cnt_d   = '0;
          w_state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!en) begin
          w_state_d = S_IDLE;
        end else begin
          w_rem_d = w_rem_step;
          w_dvd_d = w_quo_step;
          w_cnt_d = r_cnt_q + 1'b1;
          if (r_cnt_q == CNT_LAST) begin
            w_quotient_d  = w_quo_fix;
            w_remainder_d = w_rem_fix;
            w_done_d      = 1'b1;
            w_state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!en) begin
          w_state_d = S_IDLE;
        end
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= S_IDLE;
      r_cnt_q   <= '0;
      r_rem_q   <= '0;
      r_dvd_q   <= '0;
      r_dvs_q   <= '0;
      r_qneg_q  <= 1'b0;
      r_rneg_q  <= 1'b0;
      r_dz_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_rem_q   <= w_rem_d;
      r_dvd_q   <= w_dvd_d;
      r_dvs_q   <= w_dvs_d;
      r_qneg_q  <= w_qneg_d;
      r_rneg_q  <= w_rneg_d;
      r_dz_q    <= w_dz_d;
      quotient  <= w_quotient_d;
      remainder <= w_remainder_d;
      done      <= w_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_subshift.sv
// ============================================================================
// Module      : tb_div_subshift
// Description : Directed self-checking bench for div_subshift (DATA_W=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_subshift;

  localparam int DATA_W = 32;
  localparam int TIMEOUT = 40;

  logic              clk;
  logic              rst;
  logic              en;
  logic              sign;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              done;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  div_subshift #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference built on the language's own truncating division operators.
  task automatic model(input logic s, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                       output logic [DATA_W-1:0] q, output logic [DATA_W-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Start an operation, scramble operands after the start edge, wait for done
  // within a bounded budget, compare against the scoreboard, then hold en.
  task automatic run_op(input string tag, input logic s, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] eq,
                        input logic [DATA_W-1:0] er, input int hold);
    exp_t e;
    int   n;
    e.tag = tag;
    e.q   = eq;
    e.r   = er;
    sb.push_back(e);
    sign     = s;
    dividend = a;
    divisor  = b;
    en       = 1'b1;
    @(negedge clk);
    n = 1;
    sign     = ~s;
    dividend = $urandom;
    divisor  = $urandom;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    e = sb.pop_front();
    check({e.tag, "_q"}, 64'(quotient), 64'(e.q));
    check({e.tag, "_r"}, 64'(remainder), 64'(e.r));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_done"}, 64'(done), 64'd0);
      check({tag, "_hold_q"}, 64'(quotient), 64'(e.q));
      check({tag, "_hold_r"}, 64'(remainder), 64'(e.r));
    end
    en = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] mq;
    logic [DATA_W-1:0] mr;
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    logic              rs;
    rst      = 1'b1;
    en       = 1'b0;
    sign     = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_done", 64'(done), 64'd0);
    check("reset_q", 64'(quotient), 64'd0);
    check("reset_r", 64'(remainder), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    check("u100_7_done_one_cycle", 64'(done), 64'd0);
    run_op("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1);
    run_op("s100_-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1);
    run_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
    run_op("s-5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1);

    // Abort during busy cycle 10: previous results (-5/0) must survive.
    sign     = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd3;
    en       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abort_busy_done", 64'(done), 64'd0);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_done", 64'(done), 64'd0);
      check("abort_q", 64'(quotient), 64'hFFFF_FFFF);
      check("abort_r", 64'(remainder), 64'hFFFF_FFFB);
    end
    run_op("u9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1);

    // Reset at busy cycle 20 with en still high.
    sign     = 1'b0;
    dividend = 32'd77;
    divisor  = 32'd5;
    en       = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_q", 64'(quotient), 64'd0);
    check("rst_mid_r", 64'(remainder), 64'd0);
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      check("rst_idle_done", 64'(done), 64'd0);
    end
    run_op("u77_5_after_rst", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 5);

    for (int i = 0; i < 4; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i == 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      model(rs, ra, rb, mq, mr);
      run_op($sformatf("rand%0d", i), rs, ra, rb, mq, mr, 1);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/div_subshift.md
DIV_SUBSHIFT -- requirements
Module: div_subshift

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: start/hold request; low aborts and returns the block to idle.
REQ-005 SHALL have port sign, input, 1 bit: 1 selects two's-complement division, 0 selects unsigned; sampled with the operands.
REQ-006 SHALL have port dividend, input, DATA_W bits: numerator, sampled at start.
REQ-007 SHALL have port divisor, input, DATA_W bits: denominator, sampled at start.
REQ-008 SHALL have port quotient, output reg, DATA_W bits: result quotient.
REQ-009 SHALL have port remainder, output reg, DATA_W bits: result remainder.
REQ-010 SHALL have port done, output reg, 1 bit: one-cycle completion pulse.

Function
REQ-011 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-012 In IDLE with en=1, the block SHALL on that edge capture the operand magnitudes (negated when sign=1 and MSB set), the quotient sign (sign & (dividend MSB ^ divisor MSB)), the remainder sign (sign & dividend MSB) and a divisor-zero flag, clear the iteration counter and enter BUSY.
REQ-013 In BUSY the block SHALL perform one restoring step per cycle: shift {partial remainder, dividend} left by 1, subtract the divisor magnitude from the DATA_W+1-bit partial remainder, keep the difference when non-negative, and shift in quotient bit 1 when kept, else 0.
REQ-014 After exactly DATA_W BUSY cycles the block SHALL register quotient and remainder with sign fixups, pulse done for exactly one cycle and enter DONE.
REQ-015 done SHALL be high in the cycle after the (DATA_W+1)-th rising edge, counting the start edge as edge 1.
REQ-016 In DONE, quotient and remainder SHALL hold while en=1; with en=0 the block SHALL return to IDLE on the next edge.
REQ-017 When en is sampled 0 in BUSY, the block SHALL return to IDLE, suppress done, and leave quotient and remainder at their previous values.
REQ-018 Operand changes after the start edge SHALL have no effect on the running operation.
REQ-019 For a zero divisor (any sign mode), quotient SHALL be all ones and remainder SHALL equal dividend unmodified.
REQ-020 For signed overflow (most-negative / -1), quotient SHALL be the most-negative value and remainder SHALL be 0; this falls out of the magnitude datapath without special casing.
REQ-021 A signed remainder SHALL carry the dividend's sign, and |remainder| < |divisor| SHALL hold.
REQ-022 A new operation SHALL start only from IDLE, so en must drop for at least one cycle between operations.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL enter IDLE and clear done, quotient, remainder, the counter and all datapath registers, taking priority over en, including mid-operation.
REQ-024 With rst=1 on the first clk edge after power-up, all outputs SHALL be defined (0).

Structure
REQ-025 The block SHALL be a single flat module with no sub-module; the restoring step is a few lines of inline combinational logic.
REQ-026 No shared package SHALL be used: DATA_W is a module parameter, state encodings are local parameters, and the counter is $clog2(DATA_W)+1 bits wide.

Verification (DATA_W=32)
REQ-027 The bench SHALL cover unsigned 100 / 7 -> quotient 14, remainder 2, done high on the 33rd cycle after start, for one cycle only.
REQ-028 The bench SHALL cover signed -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; and signed 100 / -7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-029 The bench SHALL cover signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; and unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-030 The bench SHALL cover unsigned 5 / 0 -> quotient 0xFFFFFFFF, remainder 5; and signed 0xFFFFFFFB / 0 -> quotient 0xFFFFFFFF, remainder 0xFFFFFFFB.
REQ-031 The bench SHALL cover en dropped at BUSY cycle 10 -> no done pulse and outputs unchanged; then a fresh 9 / 3 -> quotient 3, remainder 0 with correct latency.
REQ-032 The bench SHALL cover rst pulsed at BUSY cycle 20 -> next cycle done=0, quotient=0, remainder=0, state IDLE; and en held 5 cycles past done -> outputs stable and done low.
